// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types for the pipeline hazard controller:
//   hz_state_e     data-RAM handshake sequencer states (RUN / DWAIT / DERR)
//   stall_cause_e  winning stall reason for the current cycle, in priority order
//   REG_ZERO       index of the hard-wired zero register (never a real hazard)
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        DERR  = 2'd2
    } hz_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_DATA     = 3'd1,
        CAUSE_LOAD_USE = 3'd2,
        CAUSE_MD       = 3'd3,
        CAUSE_FETCH    = 3'd4
    } stall_cause_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_dwait_timer.sv
// -----------------------------------------------------------------------------
// dwait_timer
// Counts cycles spent waiting on the data RAM and flags when the wait budget
// is used up.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   i_clr       restart the count at zero (entry into the wait state)
//   i_inc       one more wait cycle elapsed
//   o_expired   count has reached MAX_WAIT-1 (last allowed wait cycle)
// -----------------------------------------------------------------------------
module dwait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int            CW   = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] r_wait_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (i_clr) begin
            r_wait_cnt <= '0;
        end else if (i_inc && (r_wait_cnt != LAST)) begin
            // Saturate so a stalled handshake cannot wrap back to a fresh budget.
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign o_expired = (r_wait_cnt == LAST);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline with external RAM.
// Produces every pipeline-register enable/flush combinationally from the
// registered handshake state plus the current hazard inputs.
// Optional feature macro: HAZ_PERF_EN (adds a saturating stall-cycle counter;
// when undefined stall_cnt is tied to zero and no counter flops exist).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rs_id, rt_id, use_rt_id       ID-stage source registers
//   rt_ex, memread_ex             EX-stage load destination
//   md_start_id, md_busy          mul/div issue and unit busy
//   imem_ready                    instruction fetch data valid
//   dmem_req, dmem_ack            data RAM request / completion
//   pc_ena ... memwb_ena          pipeline register enables
//   ifid_flush, idex_flush        bubble insertion
//   bus_err                       one-cycle data RAM timeout pulse
//   stall_cnt                     cycles with pc_ena=0 (HAZ_PERF_EN only)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int RW       = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] rs_id,
    input  logic [RW-1:0] rt_id,
    input  logic          use_rt_id,
    input  logic [RW-1:0] rt_ex,
    input  logic          memread_ex,
    input  logic          md_start_id,
    input  logic          md_busy,
    input  logic          imem_ready,
    input  logic          dmem_req,
    input  logic          dmem_ack,
    output logic          pc_ena,
    output logic          ifid_ena,
    output logic          ifid_flush,
    output logic          idex_ena,
    output logic          idex_flush,
    output logic          exmem_ena,
    output logic          memwb_ena,
    output logic          bus_err,
    output logic [31:0]   stall_cnt
);

    hz_state_e    r_state;
    hz_state_e    w_state_nxt;
    stall_cause_e w_cause;
    logic         w_timer_clr;
    logic         w_timer_inc;
    logic         w_expired;
    logic         w_freeze;
    logic         w_load_use;
    logic         w_md_stall;

    dwait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_dwait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_timer_clr),
        .i_inc     (w_timer_inc),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default before any branch; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_clr = 1'b0;
        w_timer_inc = 1'b0;
        unique case (r_state)
            RUN: begin
                if (dmem_req && !dmem_ack) begin
                    w_state_nxt = DWAIT;
                    w_timer_clr = 1'b1;
                end
            end
            DWAIT: begin
                w_timer_inc = 1'b1;
                if (dmem_ack)       w_state_nxt = RUN;
                else if (w_expired) w_state_nxt = DERR;
            end
            DERR:    w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Frozen while a data access is outstanding; the ack cycle itself advances.
    assign w_freeze   = ((r_state == RUN)   && dmem_req && !dmem_ack) ||
                        ((r_state == DWAIT) && !dmem_ack);
    // The zero register is never written, so a load to it cannot create a hazard.
    assign w_load_use = memread_ex && (rt_ex != RW'(REG_ZERO)) &&
                        ((rt_ex == rs_id) || (use_rt_id && (rt_ex == rt_id)));
    assign w_md_stall = md_start_id && md_busy;

    always_comb begin
        w_cause = CAUSE_NONE;
        if (w_freeze)        w_cause = CAUSE_DATA;
        else if (w_load_use) w_cause = CAUSE_LOAD_USE;
        else if (w_md_stall) w_cause = CAUSE_MD;
        else if (!imem_ready) w_cause = CAUSE_FETCH;
    end

    always_comb begin
        pc_ena     = 1'b1;
        ifid_ena   = 1'b1;
        ifid_flush = 1'b0;
        idex_ena   = 1'b1;
        idex_flush = 1'b0;
        exmem_ena  = 1'b1;
        memwb_ena  = 1'b1;
        unique case (w_cause)
            CAUSE_DATA: begin
                pc_ena    = 1'b0;
                ifid_ena  = 1'b0;
                idex_ena  = 1'b0;
                exmem_ena = 1'b0;
                memwb_ena = 1'b0;
            end
            // Hold PC and IF/ID, let ID/EX capture a bubble, drain the rest.
            CAUSE_LOAD_USE, CAUSE_MD: begin
                pc_ena     = 1'b0;
                ifid_ena   = 1'b0;
                idex_flush = 1'b1;
            end
            CAUSE_FETCH: begin
                pc_ena     = 1'b0;
                ifid_flush = 1'b1;
            end
            default: ;
        endcase
        // Reset holds the whole pipeline, independent of the hazard inputs.
        if (rst) begin
            pc_ena     = 1'b0;
            ifid_ena   = 1'b0;
            ifid_flush = 1'b0;
            idex_ena   = 1'b0;
            idex_flush = 1'b0;
            exmem_ena  = 1'b0;
            memwb_ena  = 1'b0;
        end
    end

    assign bus_err = (r_state == DERR);

`ifdef HAZ_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!pc_ena && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
